// File: rtl/mmio_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mmio_pkg
// Brief    : Shared encodings for the MMIO load/store bridge.
// Revision : 1.0 - initial release
// ============================================================================
package mmio_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_MISAL = 2'b01;
    localparam logic [1:0] ERR_UNMAP = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Size 2'b11 is not a legal access width and is reported like a misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = |off;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_lane_align.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mmio_lane_align
// Brief    : Combinational byte-lane steering for stores, extract/extend for loads.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_lane_align
    import mmio_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_be,
    output logic [31:0] o_st_data,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [1:0]  i_ld_off,
    input  logic [31:0] i_ld_word,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_ld_byte;
    logic [15:0] w_ld_half;

    always_comb begin
        o_st_be   = 4'b0000;
        o_st_data = i_st_data;
        case (i_st_size)
            SZ_B: begin
                o_st_be   = 4'b0001 << i_st_off;
                o_st_data = {4{i_st_data[7:0]}};
            end
            SZ_H: begin
                o_st_be   = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_st_data = {2{i_st_data[15:0]}};
            end
            SZ_W: begin
                o_st_be   = 4'b1111;
                o_st_data = i_st_data;
            end
            default: begin
                o_st_be   = 4'b0000;
                o_st_data = i_st_data;
            end
        endcase
    end

    always_comb begin
        w_ld_byte = 8'h00;
        case (i_ld_off)
            2'd0:    w_ld_byte = i_ld_word[7:0];
            2'd1:    w_ld_byte = i_ld_word[15:8];
            2'd2:    w_ld_byte = i_ld_word[23:16];
            default: w_ld_byte = i_ld_word[31:24];
        endcase
        w_ld_half = i_ld_off[1] ? i_ld_word[31:16] : i_ld_word[15:0];

        o_ld_data = 32'h0;
        case (i_ld_size)
            SZ_B: o_ld_data = i_ld_unsigned ? {24'h0, w_ld_byte}
                                            : {{24{w_ld_byte[7]}}, w_ld_byte};
            SZ_H: o_ld_data = i_ld_unsigned ? {16'h0, w_ld_half}
                                            : {{16{w_ld_half[15]}}, w_ld_half};
            SZ_W: o_ld_data = i_ld_word;
            default: o_ld_data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mmio_bus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mmio_bus_ctrl
// Brief    : Table-decoded load/store bridge from the core data port to MMIO slaves.
// Revision : 1.0 - initial release
// ============================================================================
module mmio_bus_ctrl
    import mmio_pkg::*;
#(
    parameter int                     NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLV_BASE = {32'h0005_0000, 32'h0004_0000,
                                                    32'h0003_2000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLV_MASK = {32'hFFFF_FF00, 32'hFFFF_FF00,
                                                    32'hFFFF_FFF0, 32'hFFFF_0000},
    parameter int                     TIMEOUT    = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_we_i,
    input  logic [1:0]               req_size_i,
    input  logic                     req_unsigned_i,
    input  logic [31:0]              req_addr_i,
    input  logic [31:0]              req_wdata_i,
    output logic                     rsp_valid_o,
    output logic [31:0]              rsp_rdata_o,
    output logic [1:0]               rsp_err_o,
    output logic [NUM_SLAVES-1:0]    slv_sel_o,
    output logic                     slv_we_o,
    output logic [3:0]               slv_be_o,
    output logic [31:0]              slv_addr_o,
    output logic [31:0]              slv_wdata_o,
    input  logic [NUM_SLAVES*32-1:0] slv_rdata_i,
    input  logic [NUM_SLAVES-1:0]    slv_ack_i
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e                r_state_q,     w_state_d;
    logic                  r_we_q,        w_we_d;
    logic [1:0]            r_size_q,      w_size_d;
    logic                  r_uns_q,       w_uns_d;
    logic [31:0]           r_addr_q,      w_addr_d;
    logic [31:0]           r_wdata_q,     w_wdata_d;
    logic [3:0]            r_be_q,        w_be_d;
    logic [NUM_SLAVES-1:0] r_sel_q,       w_sel_d;
    logic [CNT_W-1:0]      r_cnt_q,       w_cnt_d;
    logic [31:0]           r_rsp_rdata_q, w_rsp_rdata_d;
    logic [1:0]            r_rsp_err_q,   w_rsp_err_d;

    logic [NUM_SLAVES-1:0] w_hit;
    logic [NUM_SLAVES-1:0] w_sel_dec;
    logic                  w_misal;
    logic                  w_unmap;
    logic                  w_dec_err;
    logic [31:0]           w_rdata_sel;
    logic                  w_ack;
    logic                  w_tmo;
    logic [3:0]            w_st_be;
    logic [31:0]           w_st_data;
    logic [31:0]           w_ld_data;

    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_dec
            assign w_hit[gi] = (req_addr_i & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32];
        end
    endgenerate

    // Descending scan so the lowest-indexed overlapping region wins.
    always_comb begin
        w_sel_dec = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (w_hit[i]) begin
                w_sel_dec    = '0;
                w_sel_dec[i] = 1'b1;
            end
        end
    end

    assign w_misal   = is_misaligned(req_size_i, req_addr_i[1:0]);
    assign w_unmap   = ~|w_hit;
    assign w_dec_err = w_misal | w_unmap;

    always_comb begin
        w_rdata_sel = 32'h0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel_q[i]) begin
                w_rdata_sel = w_rdata_sel | slv_rdata_i[32*i +: 32];
            end
        end
    end

    assign w_ack = |(slv_ack_i & r_sel_q);
    assign w_tmo = (r_cnt_q == C_CNT_LAST);

    mmio_lane_align u_lane (
        .i_st_size     (req_size_i),
        .i_st_off      (req_addr_i[1:0]),
        .i_st_data     (req_wdata_i),
        .o_st_be       (w_st_be),
        .o_st_data     (w_st_data),
        .i_ld_size     (r_size_q),
        .i_ld_unsigned (r_uns_q),
        .i_ld_off      (r_addr_q[1:0]),
        .i_ld_word     (w_rdata_sel),
        .o_ld_data     (w_ld_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state_q <= ST_IDLE;
        end else begin
            r_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    w_state_d = w_dec_err ? ST_RESP : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_ack || w_tmo) begin
                    w_state_d = ST_RESP;
                end
            end
            ST_RESP: w_state_d = ST_IDLE;
            default: w_state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        slv_sel_o   = '0;
        slv_we_o    = 1'b0;
        slv_be_o    = 4'b0000;
        case (r_state_q)
            ST_IDLE:   req_ready_o = 1'b1;
            ST_ACCESS: begin
                slv_sel_o = r_sel_q;
                slv_we_o  = r_we_q;
                slv_be_o  = r_be_q;
            end
            ST_RESP:   rsp_valid_o = 1'b1;
            default:   req_ready_o = 1'b0;
        endcase
    end

    assign rsp_rdata_o = r_rsp_rdata_q;
    assign rsp_err_o   = r_rsp_err_q;
    assign slv_addr_o  = r_addr_q;
    assign slv_wdata_o = r_wdata_q;

    always_comb begin
        w_we_d        = r_we_q;
        w_size_d      = r_size_q;
        w_uns_d       = r_uns_q;
        w_addr_d      = r_addr_q;
        w_wdata_d     = r_wdata_q;
        w_be_d        = r_be_q;
        w_sel_d       = r_sel_q;
        w_cnt_d       = r_cnt_q;
        w_rsp_rdata_d = r_rsp_rdata_q;
        w_rsp_err_d   = r_rsp_err_q;
        case (r_state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    w_we_d    = req_we_i;
                    w_size_d  = req_size_i;
                    w_uns_d   = req_unsigned_i;
                    w_addr_d  = req_addr_i;
                    w_wdata_d = w_st_data;
                    w_cnt_d   = '0;
                    w_sel_d   = '0;
                    w_be_d    = 4'b0000;
                    if (w_misal) begin
                        w_rsp_rdata_d = 32'h0;
                        w_rsp_err_d   = ERR_MISAL;
                    end else if (w_unmap) begin
                        w_rsp_rdata_d = 32'h0;
                        w_rsp_err_d   = ERR_UNMAP;
                    end else begin
                        w_sel_d = w_sel_dec;
                        w_be_d  = req_we_i ? w_st_be : 4'b0000;
                    end
                end
            end
            ST_ACCESS: begin
                if (w_ack) begin
                    w_rsp_rdata_d = r_we_q ? 32'h0 : w_ld_data;
                    w_rsp_err_d   = ERR_NONE;
                end else if (w_tmo) begin
                    w_rsp_rdata_d = 32'h0;
                    w_rsp_err_d   = ERR_TMO;
                end else begin
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_d = r_cnt_q;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we_q        <= 1'b0;
            r_size_q      <= SZ_B;
            r_uns_q       <= 1'b0;
            r_addr_q      <= 32'h0;
            r_wdata_q     <= 32'h0;
            r_be_q        <= 4'b0000;
            r_sel_q       <= '0;
            r_cnt_q       <= '0;
            r_rsp_rdata_q <= 32'h0;
            r_rsp_err_q   <= ERR_NONE;
        end else begin
            r_we_q        <= w_we_d;
            r_size_q      <= w_size_d;
            r_uns_q       <= w_uns_d;
            r_addr_q      <= w_addr_d;
            r_wdata_q     <= w_wdata_d;
            r_be_q        <= w_be_d;
            r_sel_q       <= w_sel_d;
            r_cnt_q       <= w_cnt_d;
            r_rsp_rdata_q <= w_rsp_rdata_d;
            r_rsp_err_q   <= w_rsp_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_bus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mmio_bus_ctrl
// Brief    : Directed self-checking bench for mmio_bus_ctrl with a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_bus_ctrl;

    localparam int NS  = 4;
    localparam int TMO = 16;
    // Region 3 overlaps region 2 so lowest-index priority can be observed.
    localparam logic [NS*32-1:0] BASE = {32'h0004_0000, 32'h0004_0000, 32'h0003_2000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'hFFFF_0000};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_we = 1'b0;
    logic [1:0]      req_size = 2'b00;
    logic            req_uns = 1'b0;
    logic [31:0]     req_addr = 32'h0;
    logic [31:0]     req_wdata = 32'h0;
    logic            rsp_valid;
    logic [31:0]     rsp_rdata;
    logic [1:0]      rsp_err;
    logic [NS-1:0]   slv_sel;
    logic            slv_we;
    logic [3:0]      slv_be;
    logic [31:0]     slv_addr;
    logic [31:0]     slv_wdata;
    logic [NS*32-1:0] slv_rdata = '0;
    logic [NS-1:0]   slv_ack = '0;

    mmio_bus_ctrl #(
        .NUM_SLAVES (NS),
        .SLV_BASE   (BASE),
        .SLV_MASK   (MASK),
        .TIMEOUT    (TMO)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_we_i       (req_we),
        .req_size_i     (req_size),
        .req_unsigned_i (req_uns),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .rsp_valid_o    (rsp_valid),
        .rsp_rdata_o    (rsp_rdata),
        .rsp_err_o      (rsp_err),
        .slv_sel_o      (slv_sel),
        .slv_we_o       (slv_we),
        .slv_be_o       (slv_be),
        .slv_addr_o     (slv_addr),
        .slv_wdata_o    (slv_wdata),
        .slv_rdata_i    (slv_rdata),
        .slv_ack_i      (slv_ack)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] base_a [NS];
    logic [31:0] mask_a [NS];

    // Expected outputs for the current cycle, maintained by the stimulus.
    logic        chk_on   = 1'b0;
    logic        e_ready  = 1'b1;
    logic        e_rvalid = 1'b0;
    logic [1:0]  e_err    = 2'b00;
    logic [31:0] e_rdata  = 32'h0;
    logic [NS-1:0] e_sel  = '0;
    logic        e_we     = 1'b0;
    logic [3:0]  e_be     = 4'h0;
    logic [31:0] e_addr   = 32'h0;
    logic [31:0] e_wdata  = 32'h0;
    logic        e_chk_addr = 1'b0;
    logic        e_chk_wd   = 1'b0;

    logic [3:0]  cap_be;
    logic [31:0] cap_wd;
    logic [NS-1:0] cap_sel;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("req_ready", 32'(req_ready), 32'(e_ready));
            check("rsp_valid", 32'(rsp_valid), 32'(e_rvalid));
            check("rsp_err",   32'(rsp_err),   32'(e_err));
            check("rsp_rdata", rsp_rdata,      e_rdata);
            check("slv_sel",   32'(slv_sel),   32'(e_sel));
            check("slv_we",    32'(slv_we),    32'(e_we));
            check("slv_be",    32'(slv_be),    32'(e_be));
            if (e_chk_addr) check("slv_addr", slv_addr, e_addr);
            if (e_chk_wd)   check("slv_wdata", slv_wdata, e_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Outcome of one request from the address map and lane rules.
    function automatic void model(input logic we, input logic [1:0] sz, input logic uns,
                                  input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                                  output logic [1:0] err, output int idx, output logic [3:0] be,
                                  output logic [31:0] wrep, output logic [31:0] rd);
        int off;
        off  = int'(a & 32'h3);
        idx  = -1;
        be   = 4'h0;
        wrep = 32'h0;
        rd   = 32'h0;
        err  = 2'b00;
        if (sz == 2'b11 || (sz == 2'b01 && (off % 2) != 0) || (sz == 2'b10 && off != 0)) begin
            err = 2'b01;
            return;
        end
        for (int i = NS - 1; i >= 0; i--) begin
            if ((a & mask_a[i]) == base_a[i]) idx = i;
        end
        if (idx < 0) begin
            err = 2'b10;
            return;
        end
        if (sz == 2'b00) begin
            wrep = (wd & 32'hFF) * 32'h0101_0101;
            be   = 4'(1 << off);
            rd   = (word >> (8 * off)) & 32'hFF;
            if (!uns && rd >= 32'h80) rd = rd + 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            wrep = (wd & 32'hFFFF) * 32'h0001_0001;
            be   = (off >= 2) ? 4'b1100 : 4'b0011;
            rd   = (word >> (8 * off)) & 32'hFFFF;
            if (!uns && rd >= 32'h8000) rd = rd + 32'hFFFF_0000;
        end else begin
            wrep = wd;
            be   = 4'hF;
            rd   = word;
        end
        if (we) rd = 32'h0;
        else    be = 4'h0;
    endfunction

    // ack_slv < 0: nobody acks; ack_slv != selected: that slave acks every cycle.
    task automatic txn(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       input int ack_slv, input int ack_dly, input logic [31:0] word,
                       input int rst_at);
        logic [1:0]  err;
        int          idx;
        logic [3:0]  be;
        logic [31:0] wrep;
        logic [31:0] rd;
        logic        done;
        model(we, sz, uns, a, wd, word, err, idx, be, wrep, rd);
        cap_be  = 4'h0;
        cap_wd  = 32'h0;
        cap_sel = '0;

        req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns;
        req_addr = a; req_wdata = wd;
        for (int i = 0; i < NS; i++) begin
            slv_rdata[32*i +: 32] = (i == idx) ? word : (~word ^ 32'(i));
        end
        step();
        req_valid = 1'b0; req_we = 1'b0; req_addr = 32'hDEAD_0001; req_wdata = 32'h0;
        e_chk_addr = 1'b0; e_chk_wd = 1'b0;
        e_ready = 1'b0;

        if (err != 2'b00) begin
            e_rvalid = 1'b1; e_err = err; e_rdata = 32'h0;
            step();
            e_rvalid = 1'b0; e_ready = 1'b1;
            return;
        end

        e_sel = NS'(1 << idx); e_we = we; e_be = be;
        e_addr = a; e_wdata = wrep; e_chk_addr = 1'b1; e_chk_wd = we;
        done = 1'b0;
        for (int k = 0; k < TMO && !done; k++) begin
            if (k == 0) begin
                cap_be = slv_be; cap_wd = slv_wdata; cap_sel = slv_sel;
            end
            slv_ack = '0;
            if (ack_slv == idx) begin
                if (k == ack_dly) slv_ack[idx] = 1'b1;
            end else if (ack_slv >= 0) begin
                slv_ack[ack_slv] = 1'b1;
            end
            if (k == rst_at) rst = 1'b1;
            step();
            if (k == rst_at) begin
                rst = 1'b0; slv_ack = '0;
                e_ready = 1'b1; e_rvalid = 1'b0; e_err = 2'b00; e_rdata = 32'h0;
                e_sel = '0; e_we = 1'b0; e_be = 4'h0;
                e_addr = 32'h0; e_wdata = 32'h0; e_chk_addr = 1'b1; e_chk_wd = 1'b1;
                return;
            end
            if ((ack_slv == idx && k == ack_dly) || k == TMO - 1) done = 1'b1;
        end
        slv_ack = '0;
        e_sel = '0; e_we = 1'b0; e_be = 4'h0; e_chk_addr = 1'b0; e_chk_wd = 1'b0;
        e_rvalid = 1'b1;
        if (ack_slv == idx && ack_dly < TMO) begin
            e_err = 2'b00; e_rdata = rd;
        end else begin
            e_err = 2'b11; e_rdata = 32'h0;
        end
        step();
        e_rvalid = 1'b0; e_ready = 1'b1;
    endtask

    initial begin
        logic [NS*32-1:0] bv;
        logic [NS*32-1:0] mv;
        bv = BASE;
        mv = MASK;
        for (int i = 0; i < NS; i++) begin
            base_a[i] = bv[32*i +: 32];
            mask_a[i] = mv[32*i +: 32];
        end

        rst = 1'b1;
        step();
        chk_on = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Byte store to GPIO, lane 1.
        txn(1'b1, 2'b00, 1'b0, 32'h0003_2001, 32'h0000_00A5, 1, 0, 32'h0, -1);
        check("lit_sb_be",  32'(cap_be),  32'h2);
        check("lit_sb_wd",  cap_wd,       32'hA5A5_A5A5);
        check("lit_sb_sel", 32'(cap_sel), 32'h2);
        check("lit_sb_err", 32'(rsp_err), 32'h0);

        txn(1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 0, 0, 32'h80FF_1234, -1);
        check("lit_lb", rsp_rdata, 32'hFFFF_FF80);
        txn(1'b0, 2'b00, 1'b1, 32'h0000_0003, 32'h0, 0, 2, 32'h80FF_1234, -1);
        check("lit_lbu", rsp_rdata, 32'h0000_0080);
        txn(1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 0, 1, 32'h80FF_1234, -1);
        check("lit_lh", rsp_rdata, 32'hFFFF_80FF);
        txn(1'b0, 2'b01, 1'b1, 32'h0000_0000, 32'h0, 0, 0, 32'h80FF_9234, -1);
        txn(1'b1, 2'b01, 1'b0, 32'h0003_2006, 32'h1234_BEEF, 1, 3, 32'h0, -1);
        check("lit_sh_be", 32'(cap_be), 32'hC);
        check("lit_sh_wd", cap_wd,      32'hBEEF_BEEF);
        // Overlapping regions 2 and 3: region 2 must be chosen.
        txn(1'b1, 2'b10, 1'b0, 32'h0004_0010, 32'hCAFE_F00D, 2, 0, 32'h0, -1);
        check("lit_overlap_sel", 32'(cap_sel), 32'h4);
        txn(1'b0, 2'b10, 1'b0, 32'h0000_0004, 32'h0, 0, 1, 32'hDEAD_BEEF, -1);
        check("lit_lw", rsp_rdata, 32'hDEAD_BEEF);

        txn(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'h0, 0, 0, 32'h1111_1111, -1);
        check("lit_misal_err", 32'(rsp_err), 32'h1);
        check("lit_misal_rd",  rsp_rdata,    32'h0);
        txn(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 0, 0, 32'h1111_1111, -1);
        txn(1'b0, 2'b01, 1'b1, 32'h0000_0001, 32'h0, 0, 0, 32'h1111_1111, -1);
        txn(1'b1, 2'b10, 1'b0, 32'h0009_0000, 32'h5555_5555, 0, 0, 32'h0, -1);
        check("lit_unmap_err", 32'(rsp_err), 32'h2);

        txn(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 0, 0, 32'h7777_0001, -1);
        // Selected slave silent while another slave acks continuously.
        txn(1'b0, 2'b10, 1'b0, 32'h0000_0008, 32'h0, 1, 0, 32'h1234_5678, -1);
        check("lit_tmo_err", 32'(rsp_err), 32'h3);
        check("lit_tmo_rd",  rsp_rdata,    32'h0);
        // Ack on the final allowed cycle beats the timeout.
        txn(1'b0, 2'b10, 1'b0, 32'h0000_000C, 32'h0, 0, TMO - 1, 32'hA0B0_C0D0, -1);
        check("lit_late_ack", rsp_rdata, 32'hA0B0_C0D0);
        txn(1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, -1, 0, 32'h0, -1);

        txn(1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0, 0, 5, 32'h0BAD_0BAD, 2);
        step();
        txn(1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0, 0, 0, 32'h0000_9A00, -1);
        check("lit_after_rst", rsp_rdata, 32'h0000_009A);
        step();
        step();

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
